ps2_key_event_decoder: RTL and testbench



---
 rtl/ps2_key_event_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 scan-code decoder: E0/F0/E1 prefix handling, held-key table, event FIFO.
// Latency: decode is combinational on the rx_valid cycle; the event is visible one cycle later.
// Backpressure: events queue in the FIFO; when it is full and not popped, the new event is dropped and overflow pulses.
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_HELD        = 8,
    parameter int SUPPRESS_REPEAT = 1,
    parameter int DROP_FAKE_SHIFT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          rx_err,
    input  logic                          ev_ready,
    output logic                          ev_valid,
    output logic [15:0]                   ev_code,
    output logic                          ev_break,
    output logic [4:0]                    held_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam bit SUPPRESS = (SUPPRESS_REPEAT != 0);
    localparam bit DROP_FAKE = (DROP_FAKE_SHIFT != 0);

    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_PAUSE} state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;

    logic         dec_vld;
    logic [15:0]  dec_code;
    logic         dec_break;
    logic         dec_pause;
    logic         bat_clr;
    logic         fake_shift;

    logic         held_vld_q [MAX_HELD];
    logic [15:0]  held_code_q [MAX_HELD];
    logic [MAX_HELD-1:0] hit_oh, free_oh;
    logic         hit;
    logic [4:0]   held_sum;

    logic [16:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]  level_q;
    logic         overflow_q;
    logic         push_req, push_acc, pop, full, repeat_drop;
    logic [16:0]  head;

    assign fake_shift = DROP_FAKE && (rx_data == 8'h12 || rx_data == 8'h59);

    // Prefix state machine: next state and the event decoded from the current byte.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dec_vld   = 1'b0;
        dec_code  = 16'h0000;
        dec_break = 1'b0;
        dec_pause = 1'b0;
        bat_clr   = 1'b0;
        if (rx_valid) begin
            if (rx_err) begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        case (rx_data)
                            8'hF0: state_d = S_BRK;
                            8'hE0: state_d = S_EXT;
                            8'hE1: begin
                                state_d = S_PAUSE;
                                cnt_d   = 3'd7;
                            end
                            8'hAA: bat_clr = 1'b1;
                            8'h00, 8'hFA, 8'hFE, 8'hEE, 8'hFF: begin
                            end
                            default: begin
                                dec_vld  = 1'b1;
                                dec_code = {8'h00, rx_data};
                            end
                        endcase
                    end
                    S_BRK: begin
                        dec_vld   = 1'b1;
                        dec_code  = {8'h00, rx_data};
                        dec_break = 1'b1;
                        state_d   = S_IDLE;
                    end
                    S_EXT: begin
                        if (rx_data == 8'hF0) begin
                            state_d = S_EXT_BRK;
                        end else begin
                            dec_vld  = !fake_shift;
                            dec_code = {8'hE0, rx_data};
                            state_d  = S_IDLE;
                        end
                    end
                    S_EXT_BRK: begin
                        dec_vld   = !fake_shift;
                        dec_code  = {8'hE0, rx_data};
                        dec_break = 1'b1;
                        state_d   = S_IDLE;
                    end
                    S_PAUSE: begin
                        // The Pause sequence body is only counted, never inspected.
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            dec_vld   = 1'b1;
                            dec_code  = 16'hE177;
                            dec_pause = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Prefix state and Pause skip counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Held-table lookup: slot holding the decoded code, and lowest free slot.
    always_comb begin
        logic free_seen;
        hit_oh    = '0;
        free_oh   = '0;
        free_seen = 1'b0;
        for (int i = 0; i < MAX_HELD; i++) begin
            if (held_vld_q[i] && held_code_q[i] == dec_code) hit_oh[i] = 1'b1;
            if (!held_vld_q[i] && !free_seen) begin
                free_oh[i] = 1'b1;
                free_seen  = 1'b1;
            end
        end
    end

    assign hit = |hit_oh;

    // Held-table update; Pause never enters the table and has no release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_HELD; i++) begin
                held_vld_q[i]  <= 1'b0;
                held_code_q[i] <= 16'h0000;
            end
        end else if (bat_clr) begin
            for (int i = 0; i < MAX_HELD; i++) held_vld_q[i] <= 1'b0;
        end else if (dec_vld && !dec_pause) begin
            for (int i = 0; i < MAX_HELD; i++) begin
                if (dec_break) begin
                    if (hit_oh[i]) held_vld_q[i] <= 1'b0;
                end else if (!hit && free_oh[i]) begin
                    held_vld_q[i]  <= 1'b1;
                    held_code_q[i] <= dec_code;
                end
            end
        end
    end

    // Number of occupied held-table slots.
    always_comb begin
        held_sum = 5'd0;
        for (int i = 0; i < MAX_HELD; i++) held_sum = held_sum + 5'(held_vld_q[i]);
    end

    assign repeat_drop = SUPPRESS && hit && !dec_break && !dec_pause;
    assign push_req    = dec_vld && !repeat_drop;
    assign full        = (level_q == FULL_LVL);
    assign pop         = ev_valid && ev_ready;
    assign push_acc    = push_req && (!full || pop);

    // FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q    <= level_q + (AW+1)'(push_acc) - (AW+1)'(pop);
            overflow_q <= push_req && full && !pop;
        end
    end

    // FIFO storage: {break, code} per entry.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= {dec_break, dec_code};
    end

    assign head       = mem_q[rd_ptr_q];
    assign ev_valid   = (level_q != '0);
    assign ev_code    = ev_valid ? head[15:0] : 16'h0000;
    assign ev_break   = ev_valid ? head[16] : 1'b0;
    assign fifo_level = level_q;
    assign held_count = held_sum;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: directed byte sequences plus a sequence-level reference model.
// Latency: model compared one step after each clock edge.
// Backpressure: ev_ready driven from the stimulus to exercise full/overflow and simultaneous pop.
module tb_ps2_key_event_decoder;

    localparam int DEPTH    = 4;
    localparam int MAX_HELD = 8;
    localparam bit SR       = 1'b1;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic        ev_ready;
    logic        ev_valid;
    logic [15:0] ev_code;
    logic        ev_break;
    logic [4:0]  held_count;
    logic [2:0]  fifo_level;
    logic        overflow;

    logic        nr_valid;
    logic [15:0] nr_code;
    logic        nr_break;
    logic [4:0]  nr_held;
    logic [2:0]  nr_level;
    logic        nr_ovf;

    int n_cmp = 0;
    int n_err = 0;
    int main_pops = 0;
    int nr_pops = 0;

    typedef struct {
        logic [15:0] code;
        bit          brk;
    } ev_t;

    logic [7:0]  pend[$];
    logic [15:0] held[$];
    ev_t         exp_q[$];
    bit          ovf_exp = 1'b0;

    ps2_key_event_decoder #(
        .FIFO_DEPTH(DEPTH), .MAX_HELD(MAX_HELD), .SUPPRESS_REPEAT(1), .DROP_FAKE_SHIFT(1)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_code(ev_code), .ev_break(ev_break),
        .held_count(held_count), .fifo_level(fifo_level), .overflow(overflow)
    );

    ps2_key_event_decoder #(
        .FIFO_DEPTH(DEPTH), .MAX_HELD(MAX_HELD), .SUPPRESS_REPEAT(0), .DROP_FAKE_SHIFT(1)
    ) dut_nr (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .ev_ready(ev_ready), .ev_valid(nr_valid), .ev_code(nr_code), .ev_break(nr_break),
        .held_count(nr_held), .fifo_level(nr_level), .overflow(nr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: interpret the byte stream as whole scan-code sequences.
    task automatic model_byte(input logic [7:0] b, output bit ev, output logic [15:0] code,
                              output bit brk, output bit is_pause);
        ev = 1'b0; code = 16'h0; brk = 1'b0; is_pause = 1'b0;
        if (pend.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0 || b == 8'hE1) pend.push_back(b);
            else if (b == 8'hAA) held.delete();
            else if (b == 8'h00 || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'hFF) ev = 1'b0;
            else begin ev = 1'b1; code = {8'h00, b}; end
        end else if (pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
                ev = 1'b1; code = 16'hE177; is_pause = 1'b1; pend.delete();
            end
        end else if (pend[0] == 8'hF0) begin
            ev = 1'b1; code = {8'h00, b}; brk = 1'b1; pend.delete();
        end else begin
            if (pend.size() == 1 && b == 8'hF0) pend.push_back(b);
            else begin
                brk  = (pend.size() == 2);
                code = {8'hE0, b};
                ev   = !(b == 8'h12 || b == 8'h59);
                pend.delete();
            end
        end
    endtask

    task automatic model_step();
        bit          pop, ev, brk, is_pause;
        logic [15:0] code;
        int          idx;
        ev_t         e;
        if (!rst) begin
            pend.delete(); held.delete(); exp_q.delete(); ovf_exp = 1'b0;
            return;
        end
        pop = (exp_q.size() > 0) && ev_ready;
        ev = 1'b0; brk = 1'b0; is_pause = 1'b0; code = 16'h0;
        if (rx_valid) begin
            if (rx_err) pend.delete();
            else model_byte(rx_data, ev, code, brk, is_pause);
        end
        if (ev && !is_pause) begin
            idx = -1;
            foreach (held[k]) if (held[k] == code) idx = k;
            if (brk) begin
                if (idx >= 0) held.delete(idx);
            end else if (idx >= 0) begin
                if (SR) ev = 1'b0;
            end else if (held.size() < MAX_HELD) held.push_back(code);
        end
        ovf_exp = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (ev) begin
            if (exp_q.size() < DEPTH) begin
                e.code = code; e.brk = brk; exp_q.push_back(e);
            end else ovf_exp = 1'b1;
        end
    endtask

    // Advance the model at each edge, then compare all outputs just after it.
    always @(posedge clk) begin
        model_step();
        #1;
        check("m_valid", 32'(ev_valid), 32'(exp_q.size() > 0));
        check("m_level", 32'(fifo_level), 32'(exp_q.size()));
        check("m_held", 32'(held_count), 32'(held.size()));
        check("m_ovf", 32'(overflow), 32'(ovf_exp));
        if (exp_q.size() > 0) begin
            check("m_code", 32'(ev_code), 32'(exp_q[0].code));
            check("m_break", 32'(ev_break), 32'(exp_q[0].brk));
        end
    end

    // Accepted-event counters for the repeat-suppression comparison.
    always @(posedge clk) begin
        if (rst && ev_valid && ev_ready) main_pops++;
        if (rst && nr_valid && ev_ready) nr_pops++;
    end

    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = err;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] drain_exp [4];
    logic [7:0]  pause_seq [8];
    logic [7:0]  fill_keys [5];
    int          base_main, base_nr;

    initial begin
        drain_exp = '{16'h0015, 16'h001D, 16'h0024, 16'h002D};
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        fill_keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0; ev_ready = 1'b1;
        idle(2);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_code", 32'(ev_code), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_held", 32'(held_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        idle(1);

        // Plain make then break.
        send(8'h1C);
        check("mk_code", 32'(ev_code), 32'h001C);
        check("mk_brk", 32'(ev_break), 32'd0);
        check("mk_held", 32'(held_count), 32'd1);
        idle(1);
        send(8'hF0); send(8'h1C);
        check("br_code", 32'(ev_code), 32'h001C);
        check("br_brk", 32'(ev_break), 32'd1);
        check("br_held", 32'(held_count), 32'd0);
        idle(1);

        // Extended keys and fake-shift drop.
        send(8'hE0); send(8'h75);
        check("ext_mk", 32'({ev_break, ev_code}), 32'h0E075);
        idle(1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_br", 32'({ev_break, ev_code}), 32'h1E075);
        idle(1);
        send(8'hE0); send(8'h12);
        check("fake_mk", 32'(ev_valid), 32'd0);
        send(8'hE0); send(8'hF0); send(8'h59);
        check("fake_br", 32'(ev_valid), 32'd0);
        idle(1);

        // Typematic repeats: one make when suppressing, three otherwise.
        base_main = main_pops; base_nr = nr_pops;
        send(8'h1C); send(8'h1C); send(8'h1C);
        idle(3);
        check("rep_sup", 32'(main_pops - base_main), 32'd1);
        check("rep_nosup", 32'(nr_pops - base_nr), 32'd3);
        send(8'hF0); send(8'h1C);
        idle(2);

        // Pause sequence, then a normal key.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("pause_pend", 32'(ev_valid), 32'd0);
            send(pause_seq[i]);
        end
        check("pause_ev", 32'({ev_break, ev_code}), 32'h0E177);
        check("pause_held", 32'(held_count), 32'd0);
        idle(1);
        send(8'h1C);
        check("post_pause", 32'({ev_break, ev_code}), 32'h0001C);
        idle(1);
        send(8'hF0); send(8'h1C);
        idle(2);

        // Fill the FIFO with ev_ready low; fifth make overflows.
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(fill_keys[i]);
        check("fill_level", 32'(fifo_level), 32'd4);
        check("fill_noovf", 32'(overflow), 32'd0);
        send(fill_keys[4]);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_held", 32'(held_count), 32'd5);
        idle(1);
        check("ovf_once", 32'(overflow), 32'd0);
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain", 32'(ev_code), 32'(drain_exp[i]));
            idle(1);
        end
        check("drained", 32'(ev_valid), 32'd0);

        // Full FIFO with a simultaneous pop accepts the push.
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'hF0); send(fill_keys[i]);
        end
        send(8'hF0);
        ev_ready = 1'b1;
        send(8'h2C);
        check("fp_noovf", 32'(overflow), 32'd0);
        check("fp_level", 32'(fifo_level), 32'd4);
        check("fp_head", 32'({ev_break, ev_code}), 32'h1001D);
        idle(5);
        check("fp_held", 32'(held_count), 32'd0);

        // rx_err after E0 abandons the prefix.
        send(8'hE0); send(8'h75, 1'b1); send(8'h1C);
        check("err_ev", 32'({ev_break, ev_code}), 32'h0001C);
        idle(1);
        check("err_only", 32'(ev_valid), 32'd0);
        send(8'hF0); send(8'h1C);
        idle(2);

        // BAT clears held keys; ack bytes are ignored.
        send(8'h1C); send(8'hAA); send(8'hFA);
        check("bat_held", 32'(held_count), 32'd0);
        check("bat_noev", 32'(ev_valid), 32'd0);

        // Reset mid-break and mid-Pause discards the partial sequence.
        send(8'hF0);
        rst = 1'b0;
        idle(1);
        check("mid_rst_held", 32'(held_count), 32'd0);
        rst = 1'b1;
        send(8'h1C);
        check("rst_brk", 32'({ev_break, ev_code}), 32'h0001C);
        idle(1);
        send(8'hE1); send(8'h14);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        send(8'h1C);
        check("rst_pause", 32'({ev_break, ev_code}), 32'h0001C);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
